// File: rtl/rgmii_ddr_tx.sv
// rgmii_ddr_tx: RGMII transmit framer (preamble/SFD insertion, abort on underrun, IFG) with DDR pin launch
module rgmii_ddr_tx #(
   parameter int IFG_CYCLES   = 12,
   parameter int PREAMBLE_LEN = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [3:0] rgmii_txd,
   output logic       rgmii_tx_ctl,
   output logic       underrun,
   output logic       frame_done
);
   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, ABORT, IFG} state_t;
   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
   localparam logic [7:0] IFG_LOAD = 8'(IFG_CYCLES - 1);
   state_t     state, state_d;
   logic [3:0] pre_cnt, pre_cnt_d;
   logic [7:0] ifg_cnt, ifg_cnt_d;
   logic [7:0] byte_d, l_byte, o_byte;
   logic       en_d, er_d, l_en, l_er, o_en, o_er;
   logic       ur_d, fd_d;
   logic [3:0] f_txd;
   logic       f_ctl;
   assign s_axis_tready = (state == DATA) || (state == ABORT);
   always_comb begin
      state_d   = state;
      pre_cnt_d = pre_cnt;
      ifg_cnt_d = ifg_cnt;
      byte_d    = 8'h00;
      en_d      = 1'b0;
      er_d      = 1'b0;
      ur_d      = 1'b0;
      fd_d      = 1'b0;
      case (state)
         IDLE: begin
            pre_cnt_d = 4'd0;
            state_d   = s_axis_tvalid ? PREAMBLE : IDLE;
         end
         PREAMBLE: begin
            byte_d    = 8'h55;
            en_d      = 1'b1;
            pre_cnt_d = pre_cnt + 4'd1;
            state_d   = (pre_cnt == PRE_LAST) ? SFD : PREAMBLE;
         end
         SFD: begin
            byte_d  = 8'hD5;
            en_d    = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            en_d = 1'b1;
            if (s_axis_tvalid) begin
               byte_d = s_axis_tdata;
               er_d   = s_axis_tuser;
               if (s_axis_tlast) begin
                  fd_d      = 1'b1;
                  state_d   = IFG;
                  ifg_cnt_d = IFG_LOAD;
               end
            end else begin
               er_d    = 1'b1;
               ur_d    = 1'b1;
               state_d = ABORT;
            end
         end
         ABORT: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               fd_d      = 1'b1;
               state_d   = IFG;
               ifg_cnt_d = IFG_LOAD;
            end
         end
         IFG: begin
            ifg_cnt_d = ifg_cnt - 8'd1;
            state_d   = (ifg_cnt == 8'd0) ? IDLE : IFG;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pre_cnt    <= 4'd0;
         ifg_cnt    <= 8'd0;
         l_byte     <= 8'h00;
         l_en       <= 1'b0;
         l_er       <= 1'b0;
         o_byte     <= 8'h00;
         o_en       <= 1'b0;
         o_er       <= 1'b0;
         underrun   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         pre_cnt    <= pre_cnt_d;
         ifg_cnt    <= ifg_cnt_d;
         l_byte     <= byte_d;
         l_en       <= en_d;
         l_er       <= er_d;
         o_byte     <= l_byte;
         o_en       <= l_en;
         o_er       <= l_er;
         underrun   <= ur_d;
         frame_done <= fd_d;
      end
   end
   // falling-half copy keeps the upper nibble and EN^ER stable for the whole low phase
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_txd <= 4'h0;
         f_ctl <= 1'b0;
      end else begin
         f_txd <= o_byte[7:4];
         f_ctl <= o_en ^ o_er;
      end
   end
   assign rgmii_txd    = clk ? o_byte[3:0] : f_txd;
   assign rgmii_tx_ctl = clk ? o_en : f_ctl;
endmodule

// File: tb/tb_rgmii_ddr_tx.sv
// tb_rgmii_ddr_tx: table-driven frame checks plus reset, underrun, back-to-back and mid-frame reset sequences
module tb_rgmii_ddr_tx;
   localparam int PRE = 7;
   localparam int IFG = 12;
   localparam int NV  = 11;
   typedef struct {
      logic [7:0] d;
      logic       u;
      logic       l;
      logic [7:0] eb;
      logic       een;
      logic       eex;
   } vec_t;
   typedef struct {
      logic [7:0] b;
      logic       en;
      logic       ex;
      logic       ur;
      logic       fd;
   } samp_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tdata = 8'h00;
   logic       tvalid = 1'b0;
   logic       tready;
   logic       tlast = 1'b0;
   logic       tuser = 1'b0;
   logic [3:0] rgmii_txd;
   logic       rgmii_tx_ctl;
   logic       underrun;
   logic       frame_done;
   int         checks = 0;
   int         failures = 0;
   samp_t      log_q[$];
   logic       rec = 1'b0;
   vec_t       tbl[NV];
   logic [3:0] m_lo;
   logic       m_en, m_ur, m_fd;
   rgmii_ddr_tx #(.IFG_CYCLES(IFG), .PREAMBLE_LEN(PRE)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .rgmii_txd(rgmii_txd), .rgmii_tx_ctl(rgmii_tx_ctl),
      .underrun(underrun), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   always begin
      @(posedge clk); #2;
      m_lo = rgmii_txd;
      m_en = rgmii_tx_ctl;
      m_ur = underrun;
      m_fd = frame_done;
      @(negedge clk); #2;
      if (rec) log_q.push_back('{b: {rgmii_txd, m_lo}, en: m_en, ex: rgmii_tx_ctl, ur: m_ur, fd: m_fd});
   end
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask
   function automatic logic [9:0] w(input int i);
      return (i >= 0 && i < log_q.size()) ? {log_q[i].b, log_q[i].en, log_q[i].ex} : 10'h3FF;
   endfunction
   function automatic int find_en(input int from);
      for (int i = from; i < log_q.size(); i++) if (log_q[i].en) return i;
      return -1;
   endfunction
   function automatic int cnt_fd();
      int c = 0;
      foreach (log_q[i]) c += int'(log_q[i].fd);
      return c;
   endfunction
   function automatic int cnt_ur();
      int c = 0;
      foreach (log_q[i]) c += int'(log_q[i].ur);
      return c;
   endfunction
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk); #1;
   endtask
   task automatic put(input logic [7:0] d, input logic u, input logic l);
      int t = 0;
      tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
      while (!tready && t < 200) begin
         @(posedge clk); @(negedge clk); #1;
         t++;
      end
      if (t >= 200) chk("put_timeout", 0, 1);
      @(posedge clk); @(negedge clk); #1;
   endtask
   task automatic start_of(input string nm, output int p);
      p = find_en(0);
      chk({nm, "_found"}, (p >= 0) ? 1 : 0, 1);
      if (p < 0) p = 0;
      for (int i = 0; i < PRE; i++) chk($sformatf("%s_pre%0d", nm, i), w(p + i), {8'h55, 2'b11});
      chk({nm, "_sfd"}, w(p + PRE), {8'hD5, 2'b11});
   endtask
   initial begin
      int p, a, b, fs;
      tbl[0]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};
      tbl[1]  = '{8'h02, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1};
      tbl[2]  = '{8'h03, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1};
      tbl[3]  = '{8'h04, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1};
      tbl[4]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};
      tbl[5]  = '{8'h02, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1};
      tbl[6]  = '{8'h03, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0};
      tbl[7]  = '{8'h04, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1};
      tbl[8]  = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1};
      tbl[9]  = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
      tbl[10] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            @(negedge clk); #3;
            rst_n = 1'b1;
         end
         @(posedge clk); #2;
         chk($sformatf("rst_hi_txd%0d", i), rgmii_txd, 0);
         chk($sformatf("rst_hi_ctl%0d", i), rgmii_tx_ctl, 0);
         chk($sformatf("rst_tready%0d", i), tready, 0);
         @(negedge clk); #2;
         chk($sformatf("rst_lo_txd%0d", i), rgmii_txd, 0);
         chk($sformatf("rst_lo_ctl%0d", i), rgmii_tx_ctl, 0);
      end
      rec = 1'b1;
      log_q.delete();
      fs = 0;
      for (int i = 0; i < NV; i++) begin
         put(tbl[i].d, tbl[i].u, tbl[i].l);
         if (tbl[i].l) begin
            tvalid = 1'b0;
            idle(IFG + 8);
            start_of($sformatf("f%0d", i), p);
            for (int j = fs; j <= i; j++)
               chk($sformatf("f%0d_byte%0d", i, j - fs), w(p + PRE + 1 + j - fs), {tbl[j].eb, tbl[j].een, tbl[j].eex});
            a = p + PRE + 1 + (i - fs + 1);
            for (int k = 0; k < IFG; k++) chk($sformatf("f%0d_ifg%0d", i, k), w(a + k) & 10'h3, 0);
            chk($sformatf("f%0d_done_cnt", i), cnt_fd(), 1);
            chk($sformatf("f%0d_ur_cnt", i), cnt_ur(), 0);
            log_q.delete();
            fs = i + 1;
         end
      end
      put(8'h01, 1'b0, 1'b0);
      put(8'h02, 1'b0, 1'b0);
      tvalid = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      put(8'h03, 1'b0, 1'b0);
      put(8'h04, 1'b0, 1'b1);
      tvalid = 1'b0;
      idle(IFG + 8);
      start_of("ur", p);
      chk("ur_b1", w(p + PRE + 1), {8'h01, 2'b11});
      chk("ur_b2", w(p + PRE + 2), {8'h02, 2'b11});
      chk("ur_err", w(p + PRE + 3), {8'h00, 2'b10});
      for (int k = 0; k < IFG + 3; k++) chk($sformatf("ur_quiet%0d", k), w(p + PRE + 4 + k) & 10'h3, 0);
      chk("ur_pulse_cnt", cnt_ur(), 1);
      chk("ur_done_cnt", cnt_fd(), 1);
      log_q.delete();
      put(8'hAA, 1'b0, 1'b1);
      put(8'hBB, 1'b0, 1'b1);
      tvalid = 1'b0;
      idle(IFG + 8);
      start_of("b2b", p);
      a = p + PRE + 1;
      chk("b2b_byte1", w(a), {8'hAA, 2'b11});
      b = find_en(a + 1);
      chk("b2b_gap", b - a - 1, IFG + 1);
      chk("b2b_pre2", w(b), {8'h55, 2'b11});
      chk("b2b_byte2", w(b + PRE + 1), {8'hBB, 2'b11});
      chk("b2b_done_cnt", cnt_fd(), 2);
      tdata = 8'h11; tuser = 1'b0; tlast = 1'b0; tvalid = 1'b1;
      p = 0;
      while (!tready && p < 200) begin
         @(posedge clk); @(negedge clk); #1;
         p++;
      end
      chk("mr_reach_data", tready, 1);
      @(posedge clk); #3;
      chk("mr_pre_ctl", rgmii_tx_ctl, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_async_txd", rgmii_txd, 0);
      chk("mr_async_ctl", rgmii_tx_ctl, 0);
      chk("mr_async_tready", tready, 0);
      tvalid = 1'b0;
      @(negedge clk); #2;
      chk("mr_lo_txd", rgmii_txd, 0);
      chk("mr_lo_ctl", rgmii_tx_ctl, 0);
      idle(2);
      rst_n = 1'b1;
      log_q.delete();
      idle(3);
      chk("mr_no_resume", (find_en(0) < 0) ? 1 : 0, 1);
      put(8'h33, 1'b0, 1'b1);
      tvalid = 1'b0;
      idle(IFG + 8);
      chk("mr_first_idle", w(0) & 10'h3, 0);
      start_of("mr", p);
      chk("mr_byte", w(p + PRE + 1), {8'h33, 2'b11});
      chk("mr_done_cnt", cnt_fd(), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
